// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register pending-write counters gating in-order issue.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback clear a source with one pending write.
module register_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [9:0] use_flags,
    input  logic [4:0] rd,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       gwb_valid,
    input  logic [4:0] gwb_addr,
    input  logic       fwb_valid,
    input  logic [4:0] fwb_addr,
    input  logic       fcwb_valid,
    output logic       any_pending,
    output logic       err_underflow
);
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    logic [CNT_W-1:0] gpr_cnt [32];
    logic [CNT_W-1:0] fpr_cnt [32];
    logic [CNT_W-1:0] fc_cnt;
    logic d_from_gpr, d_from_fpr, d_to_gpr, d_to_fpr, s_from_gpr, s_from_fpr;
    logic t_from_gpr, t_from_fpr, from_fcond, to_fcond;
    logic fire, src_busy, dst_full, fc_inc, fc_dec, uf;
    logic [31:0] g_inc, g_dec, f_inc, f_dec, g_zero, f_zero;
    assign {d_from_gpr, d_from_fpr, d_to_gpr, d_to_fpr, s_from_gpr, s_from_fpr,
            t_from_gpr, t_from_fpr, from_fcond, to_fcond} = use_flags;
    function automatic logic busy(input logic [CNT_W-1:0] c, input logic wb);
        return c != '0 && !(BYP && c == ONE && wb);
    endfunction
    function automatic logic [CNT_W-1:0] nxt(input logic [CNT_W-1:0] c, input logic inc, input logic dec);
        return (inc && !dec) ? c + ONE : (dec && !inc && c != '0) ? c - ONE : c;
    endfunction
    always_comb begin
        src_busy = (d_from_gpr && busy(gpr_cnt[rd], gwb_valid && gwb_addr == rd))
                 | (d_from_fpr && busy(fpr_cnt[rd], fwb_valid && fwb_addr == rd))
                 | (s_from_gpr && busy(gpr_cnt[rs], gwb_valid && gwb_addr == rs))
                 | (s_from_fpr && busy(fpr_cnt[rs], fwb_valid && fwb_addr == rs))
                 | (t_from_gpr && busy(gpr_cnt[rt], gwb_valid && gwb_addr == rt))
                 | (t_from_fpr && busy(fpr_cnt[rt], fwb_valid && fwb_addr == rt))
                 | (from_fcond && busy(fc_cnt, fcwb_valid));
        dst_full = (d_to_gpr && rd != '0 && gpr_cnt[rd] == MAX)
                 | (d_to_fpr && fpr_cnt[rd] == MAX)
                 | (to_fcond && fc_cnt == MAX);
        issue_ready = !src_busy && !dst_full;
        fire = issue_valid && issue_ready;
        // GPR 0 is hardwired zero: never counted, writebacks to it are dropped
        g_inc = (fire && d_to_gpr && rd != '0) ? 32'd1 << rd : '0;
        g_dec = (gwb_valid && gwb_addr != '0) ? 32'd1 << gwb_addr : '0;
        f_inc = (fire && d_to_fpr) ? 32'd1 << rd : '0;
        f_dec = fwb_valid ? 32'd1 << fwb_addr : '0;
        fc_inc = fire && to_fcond;
        fc_dec = fcwb_valid;
        for (int i = 0; i < 32; i++) begin
            g_zero[i] = gpr_cnt[i] == '0;
            f_zero[i] = fpr_cnt[i] == '0;
        end
        uf = |(g_dec & ~g_inc & g_zero) | |(f_dec & ~f_inc & f_zero) | (fc_dec && !fc_inc && fc_cnt == '0);
        any_pending = !(&g_zero) || !(&f_zero) || fc_cnt != '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr_cnt[i] <= '0;
                fpr_cnt[i] <= '0;
            end
            fc_cnt <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                gpr_cnt[i] <= nxt(gpr_cnt[i], g_inc[i], g_dec[i]);
                fpr_cnt[i] <= nxt(fpr_cnt[i], f_inc[i], f_dec[i]);
            end
            fc_cnt <= nxt(fc_cnt, fc_inc, fc_dec);
            err_underflow <= err_underflow | uf;
        end
    end
endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard: directed vectors with hand-computed expectations for register_scoreboard.
module tb_register_scoreboard;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif
    localparam logic [9:0] DFG = 10'h200, DFF = 10'h100, DTG = 10'h080, DTF = 10'h040;
    localparam logic [9:0] SFG = 10'h020, SFF = 10'h010, TFG = 10'h008, TFF = 10'h004;
    localparam logic [9:0] FFC = 10'h002, TFC = 10'h001;
    logic clk = 0, rst = 1, issue_valid = 0, issue_ready;
    logic [9:0] use_flags = '0;
    logic [4:0] rd = '0, rs = '0, rt = '0, gwb_addr = '0, fwb_addr = '0;
    logic gwb_valid = 0, fwb_valid = 0, fcwb_valid = 0, any_pending, err_underflow;
    int n_cmp = 0, n_err = 0;

    register_scoreboard #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .use_flags(use_flags), .rd(rd), .rs(rs), .rt(rt),
        .gwb_valid(gwb_valid), .gwb_addr(gwb_addr), .fwb_valid(fwb_valid), .fwb_addr(fwb_addr),
        .fcwb_valid(fcwb_valid), .any_pending(any_pending), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [9:0] f, input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        issue_valid = v;
        use_flags = f;
        rd = d;
        rs = s;
        rt = t;
        #1;
    endtask

    task automatic wb(input logic g, input logic [4:0] ga, input logic f, input logic [4:0] fa, input logic fc);
        gwb_valid = g;
        gwb_addr = ga;
        fwb_valid = f;
        fwb_addr = fa;
        fcwb_valid = fc;
        #1;
    endtask

    initial begin
        tick();
        rst = 0;
        present(0, 10'h3FF, 5, 5, 5);
        check("rst_ready", issue_ready, 1);
        check("rst_pending", any_pending, 0);
        check("rst_err", err_underflow, 0);
        // RAW on GPR 5
        present(1, DTG, 5, 0, 0);
        check("add_ready", issue_ready, 1);
        tick();
        present(1, SFG | DTG, 6, 5, 0);
        check("sub_stall", issue_ready, 0);
        check("sub_pending", any_pending, 1);
        tick();
        check("sub_stall2", issue_ready, 0);
        issue_valid = 0;
        wb(1, 5, 0, 0, 0);
        check("sub_wb_cycle", issue_ready, {31'd0, BYP});
        tick();
        wb(0, 0, 0, 0, 0);
        present(1, SFG | DTG, 6, 5, 0);
        check("sub_after_wb", issue_ready, 1);
        tick();
        present(0, 0, 0, 0, 0);
        wb(1, 6, 0, 0, 0);
        tick();
        wb(0, 0, 0, 0, 0);
        check("raw_drained", any_pending, 0);
        // GPR 0 never busy
        present(1, DTG, 0, 0, 0);
        tick();
        present(1, SFG, 0, 0, 0);
        check("r0_ready", issue_ready, 1);
        check("r0_pending", any_pending, 0);
        // flags ignored without issue_valid
        present(0, DTG | DTF | TFC, 4, 0, 0);
        tick();
        check("novalid_pending", any_pending, 0);
        // FPR 7 saturates at 3 pending writes
        present(1, DTF, 7, 0, 0);
        tick();
        tick();
        tick();
        check("fpr_full", issue_ready, 0);
        check("fpr_pending", any_pending, 1);
        wb(0, 0, 1, 7, 0);
        check("fpr_full_wb", issue_ready, 0);
        tick();
        wb(0, 0, 0, 0, 0);
        check("fpr_free", issue_ready, 1);
        present(0, 0, 0, 0, 0);
        wb(0, 0, 1, 7, 0);
        tick();
        tick();
        wb(0, 0, 0, 0, 0);
        check("fpr_drained", any_pending, 0);
        check("fpr_err", err_underflow, 0);
        // fcond RAW and simultaneous inc/dec
        present(1, TFC, 0, 0, 0);
        tick();
        present(1, FFC, 0, 0, 0);
        check("bc1t_stall", issue_ready, 0);
        tick();
        check("bc1t_stall2", issue_ready, 0);
        issue_valid = 0;
        wb(0, 0, 0, 0, 1);
        check("bc1t_wb_cycle", issue_ready, {31'd0, BYP});
        tick();
        wb(0, 0, 0, 0, 0);
        check("bc1t_free", issue_ready, 1);
        present(1, TFC, 0, 0, 0);
        tick();
        wb(0, 0, 0, 0, 1);
        check("fclt_with_wb", issue_ready, 1);
        tick();
        wb(0, 0, 0, 0, 0);
        present(0, FFC, 0, 0, 0);
        check("fc_held_busy", issue_ready, 0);
        check("fc_held_pending", any_pending, 1);
        check("fc_held_err", err_underflow, 0);
        wb(0, 0, 0, 0, 1);
        tick();
        wb(0, 0, 0, 0, 0);
        check("fc_drained", any_pending, 0);
        // underflow: GPR 0 ignored, GPR 9 flags sticky error
        wb(1, 0, 0, 0, 0);
        tick();
        wb(0, 0, 0, 0, 0);
        check("r0_wb_err", err_underflow, 0);
        wb(1, 9, 0, 0, 0);
        tick();
        wb(0, 0, 0, 0, 0);
        check("uf_set", err_underflow, 1);
        check("uf_pending", any_pending, 0);
        tick();
        present(0, SFG, 0, 9, 0);
        check("uf_sticky", err_underflow, 1);
        check("uf_cnt_zero", issue_ready, 1);
        // reset mid-operation
        present(1, DTG, 1, 0, 0);
        tick();
        present(1, DTG, 2, 0, 0);
        tick();
        present(1, DTF, 3, 0, 0);
        tick();
        present(1, TFC, 0, 0, 0);
        tick();
        present(0, SFG | TFF | FFC, 0, 1, 3);
        check("pre_rst_busy", issue_ready, 0);
        check("pre_rst_pending", any_pending, 1);
        rst = 1;
        tick();
        rst = 0;
        present(0, 10'h3FF, 1, 2, 3);
        check("post_rst_ready", issue_ready, 1);
        check("post_rst_pending", any_pending, 0);
        check("post_rst_err", err_underflow, 0);
        wb(1, 1, 0, 0, 0);
        tick();
        wb(0, 0, 0, 0, 0);
        check("stale_wb_err", err_underflow, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
